fadd_sub_pipe: RTL
==================

Name: fadd_sub_pipe

Overview:
- Pipelined 64-bit integer adder/subtractor built on the team's KGP parallel-prefix carry scheme.
- Inverse-direction companion to the combinational prefix levels: accepts a subtract command, inverts B and injects carry.
- Registers the KGP encode, prefix and sum phases into three elastic stages with a valid/ready handshake.
- Sits in the VLIW integer/FADD execution slot, feeding the writeback arbiter.

Parameters:
- WIDTH, 64, operand width; only 64 is supported (prefix network sized for 64).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit 63; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- KGP encoding per bit: 00 = kill, 11 = generate, 10 or 01 = propagate.
- Prefix combine (upper, lower): result = lower if upper is propagate, else upper.
- Carry into bit 0 is a virtual position -1: kill for add, generate for subtract.
- For subtract, B is bitwise inverted before encoding.
- Stage S1 (encode): registers kgp[2i+1:2i] from a[i] and b'[i], plus a^b', sub, tag.
- Stage S2 (prefix): Kogge-Stone prefix over 6 levels with spans 1, 2, 4, 8, 16, 32, seeded with the carry-in code. Registers each bit's group carry status c[i] = (prefix code == 11), plus xor and tag.
- Stage S3 (output): sum[i] = xor[i] ^ carry_in[i], where carry_in[0] = sub and carry_in[i] = c[i-1].
  - cout = c[63].
  - ovf = c[62] ^ c[63].
  - zero = ~|sum.
- Each stage has a valid bit vN. Stage N loads when !vN or stage N is advancing.
  - S3 advances when out_ready.
  - in_ready = !v1 | (v2 advancing or !v2 ...), i.e. the full elastic chain: ready3 = !v3 | out_ready; ready2 = !v2 | ready3; in_ready = !v1 | ready2.
  - in_ready is combinational from out_ready; no internal skid buffer.
- Latency: accepted op appears on outputs exactly 3 cycles after the accept edge when unstalled. Throughput 1/cycle.
- Backpressure: while out_valid & !out_ready, sum, flags and out_tag hold stable. Upstream stages fill; no op is lost or duplicated.
- Ordering: strictly in order.
- Simultaneous accept and output in the same cycle is legal and sustains full throughput.
- Reset (async, any time, including mid-operation): all valid bits clear and in-flight ops are discarded.
  - Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0, out_tag=0.
  - in_ready = 1 after reset.
- Data registers need no reset except the output stage.
- Wrap-around: without saturation, the result is modulo 2^64.

Optional Feature:
- FADD_SAT_EN defined: S3 applies signed saturation when ovf=1.
  - Result = 0x7FFF_FFFF_FFFF_FFFF if the true result is positive (a[63]=0 for the effective operation); 0x8000_0000_0000_0000 if negative.
  - ovf is still reported; zero is computed on the saturated value.
- Not defined: wrapping result only; no extra logic.

Test Plan:
- Add 0x0000_0000_FFFF_FFFF + 1, tag 3 -> 3 cycles later: sum=0x0000_0001_0000_0000, cout=0, ovf=0, zero=0, out_tag=3.
- Subtract 5 - 5 -> sum=0, zero=1, cout=1; subtract 0 - 1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 1 -> ovf=1, sum=0x8000_0000_0000_0000; with FADD_SAT_EN -> sum=0x7FFF_FFFF_FFFF_FFFF.
- Back-to-back 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order; then hold out_ready=0 for 5 cycles -> after 3 more accepts in_ready=0, outputs stable, nothing lost on release.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately (async); after release in_ready=1 and no stale results appear.
- Random 10k add/sub ops with random out_ready -> sum, cout and ovf match a reference model; tags match in order.

Source files
------------

// File: rtl/fadd_sub_pipe.sv
// fadd_sub_pipe: three-stage elastic 64-bit adder/subtractor on the KGP prefix scheme.
// Stages: S1 KGP encode, S2 Kogge-Stone prefix, S3 sum/flags (registered outputs).
// Optional macro FADD_SAT_EN: signed saturation of the result on overflow.
module fadd_sub_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // Prefix combine: a propagating upper group passes the lower group's status through.
    function automatic logic [1:0] kgp_combine(input logic [1:0] upper, input logic [1:0] lower);
        return (upper[1] ^ upper[0]) ? lower : upper;
    endfunction

    logic v1, v2, v3;
    logic ready1, ready2, ready3;

    logic [WIDTH-1:0]   b_eff;
    logic [2*WIDTH-1:0] kgp1;
    logic [WIDTH-1:0]   x1;
    logic               sub1;
    logic [TAG_W-1:0]   tag1;

    logic [WIDTH-1:0]   carry_c;
    logic [WIDTH-1:0]   c2;
    logic [WIDTH-1:0]   x2;
    logic               sub2;
    logic [TAG_W-1:0]   tag2;

    logic [WIDTH-1:0]   carry_in;
    logic [WIDTH-1:0]   sum_n;
    logic               ovf_n;

    // Elastic ready chain; in_ready is combinational from out_ready.
    always_comb begin
        ready3   = !v3 || out_ready;
        ready2   = !v2 || ready3;
        ready1   = !v1 || ready2;
        in_ready = ready1;
    end

    // Valid bits for all three stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ready1) v1 <= in_valid;
            if (ready2) v2 <= v1;
            if (ready3) v3 <= v2;
        end
    end

    // Subtract uses the inverted B operand.
    always_comb begin
        b_eff = sub ? ~b : b;
    end

    // S1: per-bit KGP code {a, b'} plus xor, op and tag.
    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                kgp1[2*i +: 2] <= {a[i], b_eff[i]};
            end
            x1   <= a ^ b_eff;
            sub1 <= sub;
            tag1 <= in_tag;
        end
    end

    // S2 combinational: carry-in folded into bit 0, then Kogge-Stone levels of span 1..WIDTH/2.
    always_comb begin
        logic [1:0] code [WIDTH];
        logic [1:0] next [WIDTH];
        for (int i = 0; i < int'(WIDTH); i++) begin
            code[i] = kgp1[2*i +: 2];
            next[i] = 2'b00;
        end
        code[0] = kgp_combine(code[0], sub1 ? 2'b11 : 2'b00);
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i >= (1 << l)) next[i] = kgp_combine(code[i], code[i - (1 << l)]);
                else               next[i] = code[i];
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                code[i] = next[i];
            end
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            carry_c[i] = (code[i] == 2'b11);
        end
    end

    // S2 register: group carry status per bit, xor and tag.
    always_ff @(posedge clk) begin
        if (ready2 && v1) begin
            c2   <= carry_c;
            x2   <= x1;
            sub2 <= sub1;
            tag2 <= tag1;
        end
    end

    // S3 combinational: sum bits, overflow and optional saturation.
    always_comb begin
        carry_in = {c2[WIDTH-2:0], sub2};
        ovf_n    = c2[WIDTH-1] ^ c2[WIDTH-2];
        sum_n    = x2 ^ carry_in;
`ifdef FADD_SAT_EN
        // On overflow bit 63 is kill or generate, so c2[63] equals the operand sign.
        if (ovf_n) begin
            sum_n = c2[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // S3 register: reset output stage, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            out_tag <= '0;
        end else if (ready3 && v2) begin
            sum     <= sum_n;
            cout    <= c2[WIDTH-1];
            ovf     <= ovf_n;
            zero    <= ~|sum_n;
            out_tag <= tag2;
        end
    end

    always_comb begin
        out_valid = v3;
    end

endmodule
